// File: rtl/gol_pkg.sv
// Shared constants and state type for the Game of Life generation scheduler.
package gol_pkg;

  localparam int GRID_SIZE          = 20;
  localparam int GEN_FRAMES_DEFAULT = 30;

  typedef enum logic [1:0] {
    IDLE,
    START,
    COMPUTE,
    WAIT_SWAP
  } sched_state_t;

endpackage

// File: rtl/vblank_edge_detect.sv
// Produces a one-cycle frame tick on entry to vertical blank (falling edge of vblank_n).
module vblank_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vblank_n,
  output logic o_tick
);

  logic vblank_n_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) vblank_n_q <= 1'b0;
    else       vblank_n_q <= i_vblank_n;
  end

  // Clearing the sample in reset guarantees no tick in the first cycle afterwards.
  assign o_tick = vblank_n_q & ~i_vblank_n;

endmodule

// File: rtl/gol_update_scheduler.sv
// Paces Game of Life generations to video frames, swaps the display buffer in vblank
// and arbitrates the shared cell-memory port between display and update engine.
module gol_update_scheduler
  import gol_pkg::*;
#(
  parameter int GEN_FRAMES = GEN_FRAMES_DEFAULT,
  parameter int GEN_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vblank_n,
  input  logic             i_run,
  input  logic             i_step,
  output logic             o_eng_start,
  input  logic             i_eng_done,
  output logic             o_buf_sel,
  input  logic             i_disp_req,
  output logic             o_disp_gnt,
  input  logic             i_eng_req,
  output logic             o_eng_gnt,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam logic [7:0] LAST_FRAME = 8'(GEN_FRAMES - 1);

  sched_state_t state, next_state;
  logic [7:0]   frame_cnt;
  logic         tick;
  logic         auto_trig;
  logic         swap;

  vblank_edge_detect u_edge (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_vblank_n (i_vblank_n),
    .o_tick     (tick)
  );

  assign auto_trig = tick & i_run & (frame_cnt == LAST_FRAME);
  assign swap      = (state == WAIT_SWAP) & tick;

  always_ff @(posedge i_clk) begin
    if (i_rst)         frame_cnt <= 8'd0;
    else if (tick)     frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
  end

  // NOTE: every output of this block is given a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (auto_trig | i_step) next_state = START;
      START:     next_state = COMPUTE;
      COMPUTE:   if (i_eng_done) next_state = WAIT_SWAP;
      WAIT_SWAP: if (tick) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // The done accepted in COMPUTE only arms the swap; the tick that commits it is a later one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_buf_sel   <= 1'b0;
      o_gen_count <= '0;
      o_eng_start <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= next_state;
      o_eng_start <= (state == IDLE) && (next_state == START);
      o_overrun   <= auto_trig && (state != IDLE);
      if (swap) begin
        o_buf_sel   <= ~o_buf_sel;
        o_gen_count <= o_gen_count + 1'b1;
      end
    end
  end

  assign o_busy = (state != IDLE);

  // Display always wins the shared port; the engine only gets it while computing.
  assign o_disp_gnt = i_disp_req;
  assign o_eng_gnt  = i_eng_req & ~i_disp_req & (state == COMPUTE);

endmodule
